// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared UART transmitter types and constants
// State encodings and tick-counter sizing used by uart_tx and its bench.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  localparam int OVERSAMPLE  = 16;
  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;

  // Tick counter must reach both OVERSAMPLE-1 and SB_TICK-1.
  function automatic int tick_width(input int sb_tick);
    return (sb_tick > OVERSAMPLE) ? $clog2(sb_tick) : $clog2(OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - host-side handshake and serial line bundle for uart_tx
// master = host/FIFO side plus tick source, slave = transmitter.
interface uart_tx_if;
  logic       tx_start;
  logic       s_tick;
  logic [7:0] din;
  logic       tx_busy;
  logic       tx_done_tick;
  logic       tx;

  modport master (
    output tx_start, s_tick, din,
    input  tx_busy, tx_done_tick, tx
  );

  modport slave (
    input  tx_start, s_tick, din,
    output tx_busy, tx_done_tick, tx
  );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART frame transmitter driven by a 16x oversampling tick
// Start bit, DBIT data bits LSB first, SB_TICK-tick stop; line output registered.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus
);

  localparam int             SW     = tick_width(SB_TICK);
  localparam logic [SW-1:0]  S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0]  S_STOP = SW'(SB_TICK - 1);
  localparam logic [2:0]     N_LAST = 3'(DBIT - 1);

  state_t        state_reg, state_next;
  logic [SW-1:0] s_reg, s_next;
  logic [2:0]    n_reg, n_next;
  logic [7:0]    b_reg, b_next;
  logic          tx_reg, tx_next;
  logic          done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    tx_next    = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        // A tick coinciding with the accept clock is deliberately not counted.
        if (bus.tx_start) begin
          b_next     = bus.din;
          s_next     = '0;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bus.s_tick) begin
          if (s_reg == S_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      DATA: begin
        tx_next = b_reg[0];
        if (bus.s_tick) begin
          if (s_reg == S_LAST) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_reg == N_LAST) state_next = STOP;
            else                 n_next     = n_reg + 3'd1;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (bus.s_tick) begin
          if (s_reg == S_STOP) begin
            state_next = IDLE;
            done       = 1'b1;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.tx           = tx_reg;
  assign bus.tx_busy      = (state_reg != IDLE);
  assign bus.tx_done_tick = done;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx across three parameter sets
// Stimulus pushes expected frames; a monitor decodes the selected line per tick.
module tb_uart_tx;
  import uart_tx_pkg::*;

  typedef struct {
    logic [7:0] data;
    int         nbits;
    int         sb;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic       s_tick;
  logic [7:0] din;
  bit         tick_en = 1'b0;
  int         tick_div = 0;
  int         sel = 0;

  frame_t exp_q[$];
  int     tests = 0;
  int     fails = 0;
  int     frames_done = 0;
  int     cyc = 0;
  int     last_done_cyc = 0;
  int     last_gap = 0;

  always #5 clk = ~clk;

  uart_tx_if if_a ();
  uart_tx_if if_b ();
  uart_tx_if if_c ();

  assign if_a.tx_start = tx_start;
  assign if_a.s_tick   = s_tick;
  assign if_a.din      = din;
  assign if_b.tx_start = tx_start;
  assign if_b.s_tick   = s_tick;
  assign if_b.din      = din;
  assign if_c.tx_start = tx_start;
  assign if_c.s_tick   = s_tick;
  assign if_c.din      = din;

  uart_tx #(.DBIT(8), .SB_TICK(16)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  uart_tx #(.DBIT(8), .SB_TICK(32)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
  uart_tx #(.DBIT(7), .SB_TICK(16)) dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

  logic m_tx, m_busy, m_done;
  int   m_dbit, m_sb;
  assign m_tx   = (sel == 0) ? if_a.tx           : (sel == 1) ? if_b.tx           : if_c.tx;
  assign m_busy = (sel == 0) ? if_a.tx_busy      : (sel == 1) ? if_b.tx_busy      : if_c.tx_busy;
  assign m_done = (sel == 0) ? if_a.tx_done_tick : (sel == 1) ? if_b.tx_done_tick : if_c.tx_done_tick;
  assign m_dbit = (sel == 2) ? 7 : 8;
  assign m_sb   = (sel == 1) ? 32 : 16;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (tick_en) begin
        tick_div = (tick_div + 1) % 4;
        s_tick   = (tick_div == 0);
      end else begin
        s_tick = 1'b0;
      end
    end
  end

  // Monitor: frame starts when busy rises; ticks are counted from the first one
  // consumed after the accept clock, and tx is sampled mid-bit.
  bit     active = 1'b0;
  bit     rst_chk = 1'b0;
  bit     lag_chk = 1'b0;
  int     cnt = 0;
  int     idx = 0;
  int     total = 0;
  logic   exp_bit;
  logic   dn;
  frame_t cur;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_chk) begin
        check("reset_tx", m_tx, 1);
        check("reset_busy", m_busy, 0);
        rst_chk = 1'b0;
      end
      if (reset) begin
        if (active) begin
          active = 1'b0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          rst_chk = 1'b1;
        end
        lag_chk = 1'b0;
        continue;
      end
      if (lag_chk) begin
        check("start_bit_lag_tx", m_tx, 0);
        lag_chk = 1'b0;
      end
      if (!active) begin
        check("idle_done", m_done, 0);
        if (m_busy) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame: got busy=1, expected idle (t=%0t)", $time);
            cur = '{8'h00, m_dbit, m_sb};
          end else begin
            cur = exp_q[0];
          end
          check("accept_clk_tx", m_tx, 1);
          lag_chk  = 1'b1;
          active   = 1'b1;
          cnt      = 0;
          last_gap = cyc - last_done_cyc;
        end
      end
      if (active) begin
        total = 16 + 16 * cur.nbits + cur.sb;
        check("busy", m_busy, 1);
        if (s_tick) cnt++;
        if (s_tick && (cnt % 16 == 8) && cnt < total) begin
          idx = cnt / 16;
          if (idx == 0)              exp_bit = 1'b0;
          else if (idx <= cur.nbits) exp_bit = cur.data[idx-1];
          else                       exp_bit = 1'b1;
          check($sformatf("bit%0d_of_%02h", idx, cur.data), m_tx, exp_bit);
        end
        dn = s_tick && (cnt == total);
        if (m_done || dn) check($sformatf("done_at_tick%0d", cnt), m_done, dn);
        if (dn || cnt > total) begin
          active = 1'b0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          frames_done++;
          last_done_cyc = cyc;
        end
      end
    end
  end

  task automatic pulse_start(input logic [7:0] d, input bit push);
    @(posedge clk);
    #2;
    din      = d;
    tx_start = 1'b1;
    if (push) exp_q.push_back('{d, m_dbit, m_sb});
    @(posedge clk);
    #2;
    tx_start = 1'b0;
    din      = ~d;
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(negedge clk);
      if (s_tick) k++;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || if_a.tx_busy || if_b.tx_busy || if_c.tx_busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d frames pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int k;
    int base;
    reset    = 1'b1;
    tx_start = 1'b0;
    din      = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_tx", if_a.tx, 1);
    check("rst_a_busy", if_a.tx_busy, 0);
    check("rst_a_done", if_a.tx_done_tick, 0);
    check("rst_b_tx", if_b.tx, 1);
    check("rst_b_busy", if_b.tx_busy, 0);
    check("rst_c_tx", if_c.tx, 1);
    check("rst_c_busy", if_c.tx_busy, 0);
    @(posedge clk);
    #2;
    reset   = 1'b0;
    tick_en = 1'b1;

    // T1: basic frame
    sel = 0;
    pulse_start(8'hA5, 1'b1);
    wait_idle("t1", 2000);

    // T2: two stop bits, all-zero data
    sel = 1;
    pulse_start(8'h00, 1'b1);
    wait_idle("t2", 2000);

    // T3: starts while busy are dropped; tick pause mid-frame holds everything
    sel = 0;
    pulse_start(8'h3C, 1'b1);
    wait_ticks(38);
    pulse_start(8'hFF, 1'b0);
    tick_en = 1'b0;
    repeat (40) @(posedge clk);
    tick_en = 1'b1;
    wait_ticks(58);
    pulse_start(8'hFF, 1'b0);
    wait_idle("t3", 2500);

    // T4: reset mid-frame, then a clean frame
    pulse_start(8'h77, 1'b1);
    wait_ticks(68);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    pulse_start(8'h5A, 1'b1);
    wait_idle("t4", 2000);

    // T5: tx_start held across two frames
    base = frames_done;
    @(posedge clk);
    #2;
    din      = 8'h11;
    tx_start = 1'b1;
    exp_q.push_back('{8'h11, 8, 16});
    exp_q.push_back('{8'h11, 8, 16});
    k = 0;
    while (frames_done < base + 1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #2;
    tx_start = 1'b0;
    wait_idle("t5", 2000);
    check("t5_frames", frames_done - base, 2);
    check("t5_gap_clks", last_gap, 2);

    // T6: seven data bits
    sel = 2;
    pulse_start(8'hFF, 1'b1);
    wait_idle("t6", 2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
